// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared widths, state and lane encodings for the data-memory unit
package cpu_mem_pkg;
    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;
    typedef enum logic {IDLE, SPLIT} dmem_state_t;
    typedef enum logic [1:0] {FMT_WORD, FMT_HI, FMT_LO, FMT_SPLIT} dmem_fmt_t;
    localparam logic [1:0] HI_LANE = 2'b10;
    localparam logic [1:0] LO_LANE = 2'b01;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port DEPTH_WORDS x 16 RAM, per-byte write enables, synchronous read-old-data
module dmem_ram
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           i_en,
    input  logic [1:0]                     i_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [WORD_W-1:0]              i_d,
    output logic [WORD_W-1:0]              o_q
);
    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    // byte-lane writes; the read port returns the row as it was before this edge
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we[1]) r_mem[i_addr][15:8] <= i_d[15:8];
            if (i_we[0]) r_mem[i_addr][7:0] <= i_d[7:0];
            o_q <= r_mem[i_addr];
        end
    end
endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: big-endian lw/sw/lbu/sb responder; misaligned words split over two cycles,
// or trapped via align_err when DMEM_ALIGN_TRAP_EN is defined
module data_mem_unit
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              byte_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              rvalid,
    output logic              stall,
    output logic              align_err
);
    localparam int RW = $clog2(DEPTH_WORDS);

    dmem_state_t       r_state, w_next;
    dmem_fmt_t         r_fmt, w_fmt;
    logic              r_split_wr, r_rvalid;
    logic [BYTE_W-1:0] r_hold;
    logic [WORD_W-1:0] r_rdata, w_rdata, w_q, w_d;
    logic              w_en, w_ld, w_stall, w_trap;
    logic [1:0]        w_we;
    logic [RW-1:0]     w_row, w_ra;
    logic              w_unused;

    assign w_row    = addr[RW:1];
    assign w_unused = ^addr[ADDR_W-1:RW+1];

    // decode the request into one RAM access, stall and next state; writes win over reads
    always_comb begin
        w_en    = 1'b0;
        w_we    = 2'b00;
        w_d     = wdata;
        w_ra    = w_row;
        w_stall = 1'b0;
        w_ld    = 1'b0;
        w_fmt   = FMT_WORD;
        w_trap  = 1'b0;
        w_next  = IDLE;
        if (!reset) begin
            w_next = IDLE;
`ifndef DMEM_ALIGN_TRAP_EN
        end else if (r_state == SPLIT) begin
            w_en  = 1'b1;
            w_ra  = w_row + 1'b1;
            w_we  = r_split_wr ? HI_LANE : 2'b00;
            w_d   = {2{wdata[7:0]}};
            w_ld  = ~r_split_wr;
            w_fmt = FMT_SPLIT;
`endif
        end else if (mem_read || mem_write) begin
            if (byte_en) begin
                w_en  = 1'b1;
                w_we  = mem_write ? (addr[0] ? LO_LANE : HI_LANE) : 2'b00;
                w_d   = {2{wdata[7:0]}};
                w_ld  = ~mem_write;
                w_fmt = addr[0] ? FMT_LO : FMT_HI;
            end else if (!addr[0]) begin
                w_en = 1'b1;
                w_we = mem_write ? 2'b11 : 2'b00;
                w_ld = ~mem_write;
            end else begin
`ifdef DMEM_ALIGN_TRAP_EN
                w_trap = 1'b1;
`else
                w_en    = 1'b1;
                w_we    = mem_write ? LO_LANE : 2'b00;
                w_d     = {2{wdata[15:8]}};
                w_stall = 1'b1;
                w_next  = SPLIT;
`endif
            end
        end
    end

    // load data comes straight from the RAM output on the rvalid cycle, otherwise the last result
    assign w_rdata = !r_rvalid ? r_rdata :
                     r_fmt == FMT_SPLIT ? {r_hold, w_q[15:8]} :
                     r_fmt == FMT_HI ? {8'h00, w_q[15:8]} :
                     r_fmt == FMT_LO ? {8'h00, w_q[7:0]} : w_q;

    // state, load bookkeeping and the high byte of a split load
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_hold     <= '0;
            r_split_wr <= 1'b0;
            r_fmt      <= FMT_WORD;
        end else begin
            r_state  <= w_next;
            r_rvalid <= w_ld;
            r_rdata  <= w_rdata;
            if (w_next == SPLIT) r_split_wr <= mem_write;
            if (r_state == SPLIT) r_hold <= w_q[7:0];
            if (w_ld) r_fmt <= w_fmt;
        end
    end

`ifdef DMEM_ALIGN_TRAP_EN
    logic r_align_err;
    // one-cycle trap pulse after a rejected misaligned word access
    always_ff @(posedge clk) begin
        if (!reset) r_align_err <= 1'b0;
        else r_align_err <= w_trap;
    end
    assign align_err = r_align_err;
`else
    assign align_err = 1'b0 & w_trap;
`endif

    assign rdata  = w_rdata;
    assign rvalid = r_rvalid;
    assign stall  = w_stall;

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .i_en  (w_en),
        .i_we  (w_we),
        .i_addr(w_ra),
        .i_d   (w_d),
        .o_q   (w_q)
    );
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: randomized scoreboard bench against a byte-array memory model
module tb_data_mem_unit;
`ifdef DMEM_ALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clk = 0, reset = 0, mem_read = 0, mem_write = 0, byte_en = 0;
    logic [15:0] addr = 0, wdata = 0, rdata;
    logic rvalid, stall, align_err;

    data_mem_unit #(.DEPTH_WORDS(256), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .byte_en(byte_en), .addr(addr), .wdata(wdata), .rdata(rdata),
        .rvalid(rvalid), .stall(stall), .align_err(align_err)
    );

    always #5 clk = ~clk;

    logic [7:0] bm [512];
    int due_q[$];
    logic [15:0] dat_q[$];
    int cyc = 0, n_chk = 0, n_fail = 0;
    logic mon_on = 0, exp_ae = 0, rst_edge = 0;
    logic [15:0] last = 0;

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_edge <= !reset;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (rst_edge) last = 16'h0000;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                chk("rvalid", {15'b0, rvalid}, 16'd1);
                chk("rdata", rdata, dat_q[0]);
                last = dat_q[0];
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end else begin
                chk("rvalid_idle", {15'b0, rvalid}, 16'd0);
                chk("rdata_hold", rdata, last);
            end
            chk("align_err", {15'b0, align_err}, {15'b0, exp_ae});
        end
    end

    task automatic op(input logic rd, input logic wr, input logic be, input logic [15:0] a, input logic [15:0] wd);
        logic [8:0] i0, i1;
        logic mis;
        i0 = a[8:0];
        i1 = i0 + 9'd1;
        mis = !be && a[0] && (rd || wr);
        mem_read = rd; mem_write = wr; byte_en = be; addr = a; wdata = wd;
        #1;
        chk("stall", {15'b0, stall}, {15'b0, mis && !TRAP});
        if (!(mis && TRAP)) begin
            if (rd && !wr) begin
                due_q.push_back(cyc + (mis ? 2 : 1));
                dat_q.push_back(be ? {8'h00, bm[i0]} : {bm[i0], bm[i1]});
            end
            if (wr && be) bm[i0] = wd[7:0];
            if (wr && !be) begin
                bm[i0] = wd[15:8];
                bm[i1] = wd[7:0];
            end
        end
        @(posedge clk); #1;
        exp_ae = mis && TRAP;
        if (mis && !TRAP) begin
            chk("stall_split", {15'b0, stall}, 16'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) op(0, 0, 0, 16'h0, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_rvalid", {15'b0, rvalid}, 16'd0);
        chk("rst_stall", {15'b0, stall}, 16'd0);
        chk("rst_align_err", {15'b0, align_err}, 16'd0);
        reset = 1;
        mon_on = 1;
        for (int r = 0; r < 256; r++) op(0, 1, 0, 16'(2 * r), 16'($urandom));
        op(0, 1, 0, 16'h0010, 16'hBEEF);
        op(1, 0, 0, 16'h0010, 16'h0);
        op(0, 1, 1, 16'h0011, 16'h0042);
        op(1, 0, 1, 16'h0011, 16'h0);
        op(1, 0, 0, 16'h0010, 16'h0);
        op(0, 1, 0, 16'h0021, 16'h1234);
        op(1, 0, 0, 16'h0020, 16'h0);
        op(1, 0, 0, 16'h0022, 16'h0);
        op(1, 0, 0, 16'h0021, 16'h0);
        op(0, 1, 0, 16'h01FF, 16'hA55A);
        op(1, 0, 0, 16'h01FE, 16'h0);
        op(1, 0, 0, 16'h0000, 16'h0);
        op(1, 0, 0, 16'h01FF, 16'h0);
        op(1, 1, 0, 16'h0030, 16'h7777);
        op(1, 0, 0, 16'h0030, 16'h0);
        op(1, 0, 0, 16'h0041, 16'h0);
        op(1, 0, 0, 16'h0040, 16'h0);
        idle(2);
        for (int k = 0; k < 400; k++) begin
            int kind;
            logic [15:0] a;
            kind = $urandom_range(0, 3);
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 511));
            op(kind[0], kind[1], 1'($urandom_range(0, 1)), a, 16'($urandom));
        end
        if (!TRAP) begin
            op(0, 1, 0, 16'h0050, 16'h1111);
            op(0, 1, 0, 16'h0052, 16'h2222);
            mem_read = 0; mem_write = 1; byte_en = 0; addr = 16'h0051; wdata = 16'hC3D4;
            #1;
            chk("rst_split_stall1", {15'b0, stall}, 16'd1);
            bm[9'h051] = 8'hC3;
            @(posedge clk); #1;
            reset = 0;
            #1;
            chk("rst_split_stall0", {15'b0, stall}, 16'd0);
            @(posedge clk); #1;
            reset = 1;
            mem_write = 0;
            #1;
            chk("post_rst_stall", {15'b0, stall}, 16'd0);
            op(1, 0, 0, 16'h0050, 16'h0);
            op(1, 0, 0, 16'h0052, 16'h0);
        end
        idle(4);
        chk("queue_empty", 16'(due_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
